// File: rtl/mac_result_drain_if.sv
// Result stream between mac_result_drain and the downstream sink.
// master drives the FIFO head and valid; slave returns ready.
interface mac_result_drain_if #(
  parameter int OUT_W = 16
);
  logic [OUT_W-1:0] out_data;
  logic             out_sat;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_sat,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_sat,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/mac_result_drain.sv
// Sequences LEN-step dot-product frames into the mac accumulator, then rounds,
// saturates and queues each 40-bit result onto a 16-bit valid/ready stream.
module mac_result_drain #(
  parameter int ACC_W      = 40,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 8,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [LEN_W-1:0]    len,
  input  logic                mac_step,
  input  logic [ACC_W-1:0]    acc_in,
  output logic                in_ready,
  output logic                mac_clr,
  output logic                busy,
  mac_result_drain_if.master  res
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CLEAR   = 3'd1;
  localparam logic [2:0] COUNT   = 3'd2;
  localparam logic [2:0] SETTLE  = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic signed [ACC_W:0] ONE  = {{ACC_W{1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0] HALF = ONE <<< (FRAC_SHIFT - 1);
  localparam logic signed [ACC_W:0] SMAX = (ONE <<< (OUT_W - 1)) - ONE;
  localparam logic signed [ACC_W:0] SMIN = '0 - (ONE <<< (OUT_W - 1));

  logic [2:0]        state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;

  logic              push;
  logic              pop;
  logic              push_ok;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [OUT_W-1:0]  mem_data [FIFO_DEPTH];
  logic              mem_sat  [FIFO_DEPTH];

  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] shf;
  logic [OUT_W-1:0]      res_data;
  logic                  res_sat;

  // Round half up, then clamp to the signed output range
  always_comb begin
    rnd      = $signed({acc_in[ACC_W-1], acc_in}) + HALF;
    shf      = rnd >>> FRAC_SHIFT;
    res_data = shf[OUT_W-1:0];
    res_sat  = 1'b0;
    if (shf > SMAX) begin
      res_data = {1'b0, {(OUT_W-1){1'b1}}};
      res_sat  = 1'b1;
    end else if (shf < SMIN) begin
      res_data = {1'b1, {(OUT_W-1){1'b0}}};
      res_sat  = 1'b1;
    end
  end

  assign pop     = res.out_valid & res.out_ready;
  assign push_ok = (count < DEPTH_C) | pop;
  assign push    = (state == CAPTURE) & push_ok;

  // len_q - 1 wraps to all-ones for len==0, giving a 2**LEN_W step frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      len_q <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) state <= CLEAR;
        end
        CLEAR: begin
          len_q <= len;
          cnt   <= '0;
          state <= COUNT;
        end
        COUNT: begin
          if (mac_step) begin
            cnt <= cnt + 1'b1;
            if (cnt == len_q - 1'b1) state <= SETTLE;
          end
        end
        SETTLE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          if (push_ok) state <= enable ? CLEAR : IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= res_data;
      mem_sat[wr_ptr]  <= res_sat;
    end
  end

  assign in_ready      = (state == COUNT);
  assign mac_clr       = (state == CLEAR);
  assign busy          = (state != IDLE);
  assign res.out_valid = (count != '0);
  assign res.out_data  = res.out_valid ? mem_data[rd_ptr] : '0;
  assign res.out_sat   = res.out_valid ? mem_sat[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_mac_result_drain.sv
// Directed + randomized bench for mac_result_drain with an arithmetic
// reference model and an expected-result queue.
module tb_mac_result_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  len;
  logic        mac_step;
  logic [39:0] acc_in;
  logic        in_ready;
  logic        mac_clr;
  logic        busy;

  mac_result_drain_if #(.OUT_W(16)) res ();

  mac_result_drain #(
    .ACC_W(40), .OUT_W(16), .FRAC_SHIFT(8), .LEN_W(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .len(len),
    .mac_step(mac_step), .acc_in(acc_in), .in_ready(in_ready),
    .mac_clr(mac_clr), .busy(busy), .res(res)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  bit          rand_ready = 1'b0;
  logic [16:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: floor((acc + 128) / 256) clamped to int16
  function automatic logic [16:0] model(input logic [39:0] a);
    longint v, r, s;
    v = longint'($signed(a));
    r = v + 128;
    if (r >= 0) s = r / 256;
    else        s = -((-r + 255) / 256);
    if (s > 32767)  return {1'b1, 16'h7FFF};
    if (s < -32768) return {1'b1, 16'h8000};
    return {1'b0, s[15:0]};
  endfunction

  function automatic logic [39:0] rand_acc();
    logic [63:0] w;
    longint      k;
    w = {$urandom, $urandom};
    case ($urandom_range(3))
      0: k = longint'($signed(w[24:0]));
      1: k = (w[0] ? -1 : 1) * (32767 * 256 + longint'($urandom_range(400)) - 200);
      2: k = longint'($signed(w[39:0]));
      default: k = longint'($signed(w[20:8])) * 256 + 127 + longint'(w[1]);
    endcase
    return k[39:0];
  endfunction

  // Checks any handshake happening on the coming edge, then advances one cycle
  task automatic tick();
    logic [16:0] e;
    if (rand_ready) res.out_ready = ($urandom_range(2) != 0);
    if (res.out_valid && res.out_ready) begin
      pops++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL pop_unexpected observed=%0h expected=none", {res.out_sat, res.out_data});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pop_result", {47'b0, res.out_sat, res.out_data}, {47'b0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Runs one frame of n steps (0 => 256); returns in SETTLE with len set to nxt
  task automatic run_frame(input int n, input logic [39:0] a, input int gap_pct, input int nxt);
    int w;
    int steps;
    int issued;
    w = 0;
    while (!in_ready && w < 300) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", {63'b0, in_ready}, 64'd1);
      return;
    end
    acc_in = a;
    steps  = (n == 0) ? 256 : n;
    issued = 0;
    while (issued < steps) begin
      mac_step = ($urandom_range(99) >= gap_pct);
      if (mac_step) begin
        issued++;
        if (issued == steps) check("in_ready_last_step", {63'b0, in_ready}, 64'd1);
      end
      tick();
    end
    mac_step = 1'b0;
    exp_q.push_back(model(a));
    len = nxt[7:0];
    check("settle_in_ready", {63'b0, in_ready}, 64'd0);
  endtask

  task automatic drain();
    int w;
    w = 0;
    res.out_ready = 1'b1;
    while (exp_q.size() != 0 && w < 200) begin
      tick();
      w++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int p0;
    int cur;
    int nxt;
    reset = 1'b0; enable = 1'b0; mac_step = 1'b0; len = 8'd4; acc_in = '0;
    res.out_ready = 1'b0;
    #3;
    check("rst_outputs", {58'b0, in_ready, mac_clr, busy, res.out_valid, res.out_sat, |res.out_data}, 64'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("idle_busy", {63'b0, busy}, 64'd0);

    // Basic frame and latency
    enable = 1'b1;
    tick();
    check("first_clr", {63'b0, mac_clr}, 64'd1);
    run_frame(4, 40'h00_0000_0500, 0, 4);
    tick();
    check("capture_valid", {63'b0, res.out_valid}, 64'd0);
    check("capture_in_ready", {63'b0, in_ready}, 64'd0);
    tick();
    check("lat_valid", {63'b0, res.out_valid}, 64'd1);
    check("lat_data", {48'b0, res.out_data}, 64'h0005);
    check("lat_sat", {63'b0, res.out_sat}, 64'd0);
    check("lat_next_clr", {63'b0, mac_clr}, 64'd1);
    tick();
    check("clr_one_cycle", {63'b0, mac_clr}, 64'd0);
    check("count_in_ready", {63'b0, in_ready}, 64'd1);
    res.out_ready = 1'b1;

    // Rounding and saturation corners
    run_frame(4, 40'h00_0000_0180, 30, 2);
    run_frame(2, 40'hFF_FFFF_FE80, 30, 3);
    run_frame(3, 40'h00_0100_0000, 30, 1);
    run_frame(1, 40'hFF_0000_0000, 0, 5);
    drain();

    // Back-pressure: four queued, fifth held in CAPTURE
    res.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) run_frame(5, rand_acc(), 20, 5);
    for (int i = 0; i < 6; i++) tick();
    check("hold_in_ready", {63'b0, in_ready}, 64'd0);
    check("hold_busy", {63'b0, busy}, 64'd1);
    check("hold_valid", {63'b0, res.out_valid}, 64'd1);
    enable = 1'b0;
    p0 = pops;
    drain();
    check("hold_pop_count", 64'(pops - p0), 64'd5);
    tick(); tick();
    check("enable_drop_idle", {63'b0, busy}, 64'd0);
    check("enable_drop_empty", {63'b0, res.out_valid}, 64'd0);

    // Asynchronous reset mid-COUNT, then len=0 frame
    len = 8'd6;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    acc_in = 40'h00_0000_1234;
    mac_step = 1'b1;
    tick(); tick();
    res.out_ready = 1'b0;
    len = 8'd0;
    reset = 1'b0;
    #2;
    check("async_rst_outputs", {58'b0, in_ready, mac_clr, busy, res.out_valid, res.out_sat, |res.out_data}, 64'd0);
    mac_step = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("rst_release_clr", {63'b0, mac_clr}, 64'd1);
    tick();
    check("rst_release_in_ready", {63'b0, in_ready}, 64'd1);
    res.out_ready = 1'b1;

    acc_in = 40'h00_0000_2280;
    mac_step = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    check("len0_not_early", {63'b0, in_ready}, 64'd1);
    tick();
    check("len0_close", {63'b0, in_ready}, 64'd0);
    exp_q.push_back(model(40'h00_0000_2280));
    len = 8'd3;
    tick(); tick();
    mac_step = 1'b0;
    run_frame(3, 40'h00_0000_0080, 10, 3);
    drain();

    // Randomized frames with random back-pressure
    rand_ready = 1'b1;
    cur = 3;
    for (int i = 0; i < 24; i++) begin
      nxt = $urandom_range(8, 1);
      run_frame(cur, rand_acc(), 25, nxt);
      cur = nxt;
    end
    enable = 1'b0;
    rand_ready = 1'b0;
    drain();
    tick(); tick();
    check("final_idle", {63'b0, busy}, 64'd0);
    check("final_empty", {63'b0, res.out_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
